// File: rtl/wall_query_arbiter.sv
// Round-robin arbiter sharing the maze wall ROM between Pac-Man and the ghosts.
// Converts pixel coordinates to tile addresses, pipelines ROM reads and routes each wall bit home.
module wall_query_arbiter #(
    parameter int N_REQ      = 5,
    parameter int TILE_SHIFT = 3,
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int ADDR_W     = 13,
    parameter int ROM_LAT    = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  pause,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*10-1:0]   req_x,
    input  logic [N_REQ*10-1:0]   req_y,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic                  rsp_wall,
    output logic                  rom_rd,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic                  rom_data,
    output logic                  busy
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int X_MAX = COLS << TILE_SHIFT;
    localparam int Y_MAX = ROWS << TILE_SHIFT;

    logic [N_REQ-1:0]  r_gnt;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic              r_rsp_wall;
    logic              r_rom_rd;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [N_REQ-1:0]  r_out;
    logic [ID_W-1:0]   r_rr;
    logic [ROM_LAT:0]  r_tag_v;
    logic [ROM_LAT:0]  r_tag_oob;
    logic [ID_W-1:0]   r_tag_id [ROM_LAT+1];

    logic [N_REQ-1:0]  w_elig;
    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic [9:0]        w_sel_x;
    logic [9:0]        w_sel_y;
    logic [9:0]        w_col;
    logic [9:0]        w_row;
    logic              w_oob;
    logic [ADDR_W-1:0] w_addr;
    logic [N_REQ-1:0]  w_set;
    logic [N_REQ-1:0]  w_clr;

    // Search begins one past the last winner so every mover gets its turn.
    always_comb begin
        w_elig  = pause ? '0 : (req & ~r_out);
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && w_elig[(int'(r_rr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_win   = ID_W'((int'(r_rr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        w_sel_x = req_x[10*w_win +: 10];
        w_sel_y = req_y[10*w_win +: 10];
        w_col   = w_sel_x >> TILE_SHIFT;
        w_row   = w_sel_y >> TILE_SHIFT;
        w_oob   = (int'(w_sel_x) >= X_MAX) || (int'(w_sel_y) >= Y_MAX);
        w_addr  = ADDR_W'(w_row) * ADDR_W'(COLS) + ADDR_W'(w_col);
        w_set   = w_found ? (N_REQ'(1) << w_win) : '0;
        w_clr   = r_tag_v[ROM_LAT] ? (N_REQ'(1) << r_tag_id[ROM_LAT]) : '0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_wall  <= 1'b0;
            r_rom_rd    <= 1'b0;
            r_rom_addr  <= '0;
            r_out       <= '0;
            r_rr        <= ID_W'(N_REQ - 1);
            r_tag_v     <= '0;
            r_tag_oob   <= '0;
            for (int k = 0; k <= ROM_LAT; k++) r_tag_id[k] <= '0;
        end else begin
            r_gnt       <= w_set;
            r_rom_rd    <= w_found && !w_oob;
            r_out       <= (r_out & ~w_clr) | w_set;
            r_rsp_valid <= w_clr;
            // Out-of-bounds slots still travel the tag pipe so responses stay in grant order.
            r_rsp_wall  <= r_tag_v[ROM_LAT] && (r_tag_oob[ROM_LAT] || rom_data);
            r_tag_v     <= {r_tag_v[ROM_LAT-1:0], w_found};
            r_tag_oob   <= {r_tag_oob[ROM_LAT-1:0], w_oob};
            r_tag_id[0] <= w_win;
            for (int k = 1; k <= ROM_LAT; k++) r_tag_id[k] <= r_tag_id[k-1];
            if (w_found) begin
                r_rr <= w_win;
                if (!w_oob) r_rom_addr <= w_addr;
            end
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_wall  = r_rsp_wall;
    assign rom_rd    = r_rom_rd;
    assign rom_addr  = r_rom_addr;
    assign busy      = |r_out;

endmodule
